mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit owning the HI/LO special registers of the multicycle MIPS core. The core's EXEC stage issues MULT, MULTU, DIV, DIVU, MTHI and MTLO to this unit and stalls on busy. Results are read through the hi/lo outputs, which the core uses for MFHI/MFLO. Width is generic so the same block serves 32-bit and reduced-width test configurations.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; legal range is 4 to 64.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; sampled only in IDLE
op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  input  WIDTH  rs value (dividend, multiplicand, or MTHI/MTLO source)
b  input  WIDTH  rt value (divisor or multiplier)
busy  output  1  an operation is in flight; the core must stall
done  output  1  single-cycle pulse when hi/lo are updated by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal operand registers=0. Reset mid-operation aborts the operation immediately, and no done pulse is produced.
- States are IDLE, MUL, DIV, FIXUP.
- IDLE, start=1, op=MTHI/MTLO: at the next edge hi (or lo) takes the value of a. busy stays 0 and done stays 0.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes. For signed ops, abs(a) and abs(b) are computed in WIDTH+1 bits so the most-negative value is handled.
  - Latch the result sign: the product sign is sign(a)^sign(b); the quotient sign is sign(a)^sign(b); the remainder sign is sign(a).
  - Load counter=WIDTH and go to MUL or DIV.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. The counter decrements each cycle; at 0, go to FIXUP.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). The counter decrements; at 0, go to FIXUP.
- FIXUP: apply the sign corrections, write hi/lo, return to IDLE.
- Timing:
  - busy=1 in MUL, DIV and FIXUP, and 0 otherwise.
  - done=1 in the cycle after FIXUP, which is WIDTH+2 edges after the edge that sampled start.
  - A new start is accepted in the same cycle done is high.
- start while busy is ignored, including MTHI/MTLO. The core guarantees it never issues one.
- Divide by zero is defined, not UNPREDICTABLE: lo=all-ones and hi=a (the original signed/unsigned dividend). The full latency still applies.
- Signed overflow (DIV with a=most-negative and b=-1): lo=most-negative, hi=0.
- Arithmetic rules:
  - All internal arithmetic is unsigned at WIDTH+1 bits.
  - Negation is two's complement, truncated to WIDTH bits.
  - The product is {hi,lo} = 2*WIDTH bits, exact.
- hi/lo hold their values at all times except for the update edges above. The last written value remains readable while busy; the core does not read while busy.

Optional Feature:
MULDIV_FAST_MULT_EN
- Defined: MULT/MULTU skip the MUL state. IDLE goes directly to FIXUP, and a single-cycle combinational WIDTH x WIDTH product is registered there. done then pulses 2 edges after start. DIV timing is unchanged.
- Undefined: the iterative multiplier is used and WIDTH+2 latency applies to all ops.

Decomposition:
- mips_pkg holds:
  - muldiv_op_t, a 3-bit enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5);
  - muldiv_state_t, a 2-bit enum;
  - the funct constants 24/25/26/27/17/19, shared with the core's decoder.
- One sub-module, mips_div_step: a combinational single restoring-division iteration, parametrised by WIDTH, instantiated once.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 edges after start, busy high for 33 cycles.
2. MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle -> hi/lo update 1 edge after each start, done never asserted, busy never asserted.
5. DIVU a=50 b=7 started, reset asserted at cycle 10 -> next edge busy=0, hi=lo=0, no done; a new DIVU 50/7 then gives lo=7, hi=1. A start with op=MULT issued at cycle 5 of a DIV is ignored (results match DIV only).
6. WIDTH=8, with and without MULDIV_FAST_MULT_EN: MULT a=0x80 b=0x80 -> {hi,lo}=0x4000, done at 2 edges and 10 edges respectively.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mul/div op codes, mul/div FSM states and the
// R-type funct codes the decoder maps onto them.
package mips_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } muldiv_state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  // shifted < 2*divisor, so a non-negative difference always clears the top bit
  assign fits    = ~diff[WIDTH];
  assign rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o   = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_FAST_MULT_EN
// to replace the shift-add multiplier with a single-cycle product in FIXUP.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               psign_q, psign_d;
  logic               rsign_q, rsign_d;
  logic               is_div_q, is_div_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic             signed_op, is_div_op, a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic             mag_unused;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_mag;
  logic [WIDTH-1:0] rem_mag, quo_mag, div_rem, div_quo;

  assign signed_op = (op == MULT) || (op == DIV);
  assign is_div_op = (op == DIV) || (op == DIVU);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_ext     = {a_neg, a};
  assign b_ext     = {b_neg, b};
  assign a_mag     = a_neg ? -a_ext : a_ext;
  assign b_mag     = b_neg ? -b_ext : b_ext;
  assign mag_unused = a_mag[WIDTH] ^ b_mag[WIDTH];

  // Shift-add: multiplier sits in the low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  assign rem_mag = acc_q[2*WIDTH-1:WIDTH];
  assign quo_mag = acc_q[WIDTH-1:0];

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_mag),
    .quo_i     (quo_mag),
    .divisor_i (dvsr_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );
  assign div_next = {div_rem, div_quo};

`ifdef MULDIV_FAST_MULT_EN
  localparam muldiv_state_t MUL_ENTRY = ST_FIXUP;
  assign prod_mag = {{WIDTH{1'b0}}, dvsr_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  localparam muldiv_state_t MUL_ENTRY = ST_MUL;
  assign prod_mag = acc_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    psign_d  = psign_q;
    rsign_d  = rsign_q;
    is_div_d = is_div_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MTHI: hi_d = a;
            MTLO: lo_d = a;
            MULT, MULTU, DIV, DIVU: begin
              acc_d    = {{WIDTH{1'b0}}, is_div_op ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0]};
              dvsr_d   = is_div_op ? b_mag[WIDTH-1:0] : a_mag[WIDTH-1:0];
              a_d      = a;
              psign_d  = a_neg ^ b_neg;
              rsign_d  = a_neg;
              is_div_d = is_div_op;
              divz_d   = is_div_op && (b == '0);
              cnt_d    = CNT_W'(WIDTH);
              state_d  = is_div_op ? ST_DIV : MUL_ENTRY;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (is_div_q) begin
          if (divz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = psign_q ? -quo_mag : quo_mag;
            hi_d = rsign_q ? -rem_mag : rem_mag;
          end
        end else begin
          {hi_d, lo_d} = psign_q ? -prod_mag : prod_mag;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      psign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      psign_q  <= psign_d;
      rsign_q  <= rsign_d;
      is_div_q <= is_div_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8; multiply
// latency expectations follow MULDIV_FAST_MULT_EN.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT32 = 2;
  localparam int MUL_BUSY32 = 1;
  localparam int MUL_LAT8 = 2;
`else
  localparam int MUL_LAT32 = 34;
  localparam int MUL_BUSY32 = 33;
  localparam int MUL_LAT8 = 10;
`endif

  logic        clk, reset;
  logic        start32, busy32, done32;
  muldiv_op_t  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8;
  muldiv_op_t  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int nvec = 0;
  int nerr = 0;
  int edges, bcyc;

  mips_muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mips_muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges from the sampling edge up to the one raising done, bounded
  task automatic wait_done32(output int e, output int bc);
    e = 1;
    bc = 0;
    while (!done32 && e < 100) begin
      if (busy32) bc++;
      @(posedge clk); #1;
      e++;
    end
  endtask

  task automatic run32(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                       output int e, output int bc);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    wait_done32(e, bc);
  endtask

  task automatic run8(input muldiv_op_t o, input logic [7:0] x, input logic [7:0] y,
                      output int e);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e = 1;
    while (!done8 && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = MULTU; a32 = '0; b32 = '0;
    start8 = 1'b0;  op8 = MULTU;  a8 = '0;  b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy32", 64'(busy32), 64'(0));
    check("rst_done32", 64'(done32), 64'(0));
    check("rst_hilo32", {hi32, lo32}, 64'h0);
    check("rst_hilo8", 64'({hi8, lo8}), 64'h0);
    reset = 1'b0;

    run32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcyc);
    check("multu_hilo", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    check("multu_lat", 64'(edges), 64'(MUL_LAT32));
    check("multu_busy", 64'(bcyc), 64'(MUL_BUSY32));
    @(posedge clk); #1;
    check("done_pulse", 64'(done32), 64'(0));

    run32(MULT, 32'hFFFF_FFFD, 32'd5, edges, bcyc);
    check("mult_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);

    run32(DIV, 32'hFFFF_FFF9, 32'd2, edges, bcyc);
    check("div_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_lat", 64'(edges), 64'(34));
    check("div_busy", 64'(bcyc), 64'(33));

    run32(DIVU, 32'd100, 32'd0, edges, bcyc);
    check("divu_z_hilo", {hi32, lo32}, 64'h0000_0064_FFFF_FFFF);
    check("divu_z_lat", 64'(edges), 64'(34));

    run32(DIV, 32'hFFFF_FFF9, 32'd0, edges, bcyc);
    check("div_z_hilo", {hi32, lo32}, 64'hFFFF_FFF9_FFFF_FFFF);

    run32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcyc);
    check("div_ovf_hilo", {hi32, lo32}, 64'h0000_0000_8000_0000);

    // Back-to-back MTHI/MTLO
    @(negedge clk);
    op32 = MTHI; a32 = 32'h1234_5678; start32 = 1'b1;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi32), 64'h1234_5678);
    check("mthi_busy", 64'({busy32, done32}), 64'(0));
    op32 = MTLO; a32 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mtlo_hilo", {hi32, lo32}, 64'h1234_5678_9ABC_DEF0);
    check("mtlo_busy", 64'({busy32, done32}), 64'(0));
    @(posedge clk); #1;
    check("mt_idle", 64'({busy32, done32}), 64'(0));

    // Reset during a divide aborts it
    @(negedge clk);
    op32 = DIVU; a32 = 32'd50; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy32), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy32), 64'(0));
    check("abort_hilo", {hi32, lo32}, 64'h0);
    edges = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done32) edges++;
    end
    check("abort_nodone", 64'(edges), 64'(0));

    run32(DIVU, 32'd50, 32'd7, edges, bcyc);
    check("divu_hilo", {hi32, lo32}, 64'h0000_0001_0000_0007);

    // MULT issued while a DIVU is in flight is ignored
    @(negedge clk);
    op32 = DIVU; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op32 = MULT; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    wait_done32(edges, bcyc);
    check("ign_hilo", {hi32, lo32}, 64'h0000_0001_0000_014D);
    check("ign_lat", 64'(edges), 64'(29));
    @(posedge clk); #1;
    check("ign_idle", 64'({busy32, done32}), 64'(0));

    run8(MULT, 8'h80, 8'h80, edges);
    check("w8_mult_hilo", 64'({hi8, lo8}), 64'h4000);
    check("w8_mult_lat", 64'(edges), 64'(MUL_LAT8));

    run8(DIV, 8'h80, 8'hFF, edges);
    check("w8_div_ovf", 64'({hi8, lo8}), 64'h0080);
    check("w8_div_lat", 64'(edges), 64'(10));

    run8(DIVU, 8'd200, 8'd7, edges);
    check("w8_divu", 64'({hi8, lo8}), 64'h041C);

    run8(MULTU, 8'hFF, 8'h02, edges);
    check("w8_multu", 64'({hi8, lo8}), 64'h01FE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
